// File: rtl/fetch_r32i.sv
// rtl/fetch_r32i.sv - RV32I instruction fetch unit with in-order response buffer
//
// Purpose: accepts fetch addresses from the PC, issues word reads to instruction
// memory, buffers returned words in request order and presents {addr, instr} to
// decode over a valid/ready handshake. Flush discards buffered and in-flight work.
//
// Ports:
//   clock, nReset                    clock, async active-low reset
//   ProgAddr, AddrValid, AddrReady   fetch request from PC (AddrReady = accepted)
//   Flush                            branch taken, drop everything outstanding
//   MemReq, MemAddr, MemGnt          memory read request / grant
//   MemRValid, MemRData              in-order read response
//   InstrValid, InstrReady           handshake to decode
//   Instr, InstrAddr, MisalignErr    head entry contents
module fetch_r32i #(
  parameter int dataW = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             AddrValid,
  output logic             AddrReady,
  input  logic             Flush,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemGnt,
  input  logic             MemRValid,
  input  logic [dataW-1:0] MemRData,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [dataW-1:0] Instr,
  output logic [dataW-1:0] InstrAddr,
  output logic             MisalignErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [dataW-1:0] NOP = dataW'(32'h0000_0013);

  logic [dataW-1:0] addr_q [DEPTH];
  logic [dataW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] err_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    drop_q;

  logic [CW-1:0]    count;
  logic [CW-1:0]    pend_cnt;
  logic [PW-1:0]    pend_idx;
  logic [PW-1:0]    idx;
  logic             have_pend;
  logic [CW:0]      used;
  logic             room;
  logic             aligned;
  logic             req_ok;
  logic             alloc;
  logic             pop;
  logic             resp_drop;
  logic             resp_fill;

  // Occupancy and the oldest entry still waiting on memory. Valid entries are
  // contiguous from head, so the first pending one found walking from head is
  // the one the next in-order response belongs to.
  always_comb begin
    count     = '0;
    pend_cnt  = '0;
    pend_idx  = head_q;
    idx       = head_q;
    have_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) count = count + CW'(1);
      if (vld_q[i] && !done_q[i]) pend_cnt = pend_cnt + CW'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (!have_pend && vld_q[idx] && !done_q[idx]) begin
        have_pend = 1'b1;
        pend_idx  = idx;
      end
    end
  end

  // Responses still owed for flushed entries hold their credit until they return.
  assign used    = {1'b0, count} + {1'b0, drop_q};
  assign room    = used < (CW+1)'(DEPTH);
  assign aligned = (ProgAddr[1:0] == 2'b00);
  assign req_ok  = nReset && AddrValid && room && !Flush;

  assign MemReq    = req_ok && aligned;
  assign MemAddr   = MemReq ? ProgAddr : '0;
  assign AddrReady = req_ok && (!aligned || MemGnt);

  assign InstrValid  = vld_q[head_q] && done_q[head_q];
  assign Instr       = data_q[head_q];
  assign InstrAddr   = addr_q[head_q];
  assign MisalignErr = InstrValid && err_q[head_q];

  assign alloc     = AddrReady;
  assign pop       = InstrValid && InstrReady && !Flush;
  assign resp_drop = MemRValid && (drop_q != '0);
  assign resp_fill = MemRValid && (drop_q == '0) && have_pend;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vld_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (Flush) begin
      // A response landing this cycle is charged against the pre-flush state:
      // either it retires an old drop or it fills an entry about to vanish.
      vld_q  <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      drop_q <= drop_q + pend_cnt - CW'(resp_drop) - CW'(resp_fill);
    end else begin
      if (resp_drop) drop_q <= drop_q - CW'(1);
      if (resp_fill) begin
        data_q[pend_idx] <= MemRData;
        done_q[pend_idx] <= 1'b1;
      end
      if (alloc) begin
        vld_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= !aligned;
        err_q[tail_q]  <= !aligned;
        addr_q[tail_q] <= ProgAddr;
        if (!aligned) data_q[tail_q] <= NOP;
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_r32i.sv
// tb/tb_fetch_r32i.sv - self-checking bench for fetch_r32i against a queue model
module tb_fetch_r32i;

  localparam int DEPTH = 2;

  logic        clock;
  logic        nReset;
  logic [31:0] ProgAddr;
  logic        AddrValid;
  logic        AddrReady;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemGnt;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrAddr;
  logic        MisalignErr;

  fetch_r32i #(.dataW(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .nReset(nReset),
    .ProgAddr(ProgAddr), .AddrValid(AddrValid), .AddrReady(AddrReady),
    .Flush(Flush),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemGnt(MemGnt),
    .MemRValid(MemRValid), .MemRData(MemRData),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrAddr(InstrAddr), .MisalignErr(MisalignErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    logic        done;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  ent_t q[$];
  rsp_t memq[$];
  int   drop;
  int   cyc;
  int   lat_min;
  int   lat_max;
  logic rv_hold;
  logic ar_seen;
  int   checks;
  int   errors;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic av, input logic [31:0] pa, input logic fl,
                      input logic gnt, input logic ir);
    logic        rv, room, al, e_req, e_ar, e_iv, e_pop;
    logic [31:0] rd;
    int          pend;
    AddrValid  = av;
    ProgAddr   = pa;
    Flush      = fl;
    MemGnt     = gnt;
    InstrReady = ir;
    rv = (memq.size() > 0) && (memq[0].due <= cyc) && !rv_hold;
    rd = rv ? memq[0].data : $urandom;
    MemRValid = rv;
    MemRData  = rd;
    #1;
    room  = (q.size() + drop) < DEPTH;
    al    = (pa[1:0] == 2'b00);
    e_req = nReset && av && room && !fl && al;
    e_ar  = nReset && av && room && !fl && (!al || gnt);
    e_iv  = nReset && (q.size() > 0) && q[0].done;
    chk1("mem_req", MemReq, e_req);
    chk1("addr_ready", AddrReady, e_ar);
    chk1("instr_valid", InstrValid, e_iv);
    if (e_req) chk32("mem_addr", MemAddr, pa);
    if (e_iv) begin
      chk32("instr", Instr, q[0].instr);
      chk32("instr_addr", InstrAddr, q[0].addr);
      chk1("misalign_err", MisalignErr, q[0].err);
    end
    ar_seen = AddrReady;
    @(posedge clock);
    if (rv) void'(memq.pop_front());
    if (e_req && gnt) memq.push_back(rsp_t'{due: cyc + $urandom_range(lat_max, lat_min), data: $urandom});
    if (!nReset) begin
      q.delete();
      drop = 0;
    end else begin
      e_pop = e_iv && ir && !fl;
      if (rv) begin
        if (drop > 0) drop--;
        else begin
          for (int i = 0; i < q.size(); i++) begin
            if (!q[i].done) begin
              q[i].done  = 1'b1;
              q[i].instr = rd;
              break;
            end
          end
        end
      end
      if (fl) begin
        pend = 0;
        foreach (q[i]) if (!q[i].done) pend++;
        drop += pend;
        q.delete();
      end else begin
        if (e_ar) q.push_back(ent_t'{addr: pa, instr: (al ? 32'h0 : 32'h13), err: !al, done: !al});
        if (e_pop) void'(q.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] pa_list [3];
    logic [31:0] pa;
    int          k;
    int          accepted;

    checks = 0; errors = 0; cyc = 0; drop = 0;
    lat_min = 1; lat_max = 1; rv_hold = 1'b0; ar_seen = 1'b0;
    nReset = 1'b0; AddrValid = 1'b0; ProgAddr = '0; Flush = 1'b0;
    MemGnt = 1'b0; MemRValid = 1'b0; MemRData = '0; InstrReady = 1'b0;

    // Reset state, with a request presented to show it is masked.
    @(posedge clock); #1;
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
    chk32("reset_instr", Instr, 32'h0);
    chk32("reset_instr_addr", InstrAddr, 32'h0);
    chk32("reset_mem_addr", MemAddr, 32'h0);
    nReset = 1'b1;
    idle(2);

    // Streaming 0,4,8 with single-cycle latency.
    pa_list[0] = 32'h0; pa_list[1] = 32'h4; pa_list[2] = 32'h8;
    for (int i = 0; i < 3; i++) step(1'b1, pa_list[i], 1'b0, 1'b1, 1'b1);
    idle(4);

    // Backpressure: decode stalled, third fetch must wait for a pop.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pa_list[k], 1'b0, 1'b1, 1'b0);
      if (ar_seen && k < 2) k++;
    end
    chk32("bp_accepted_before_pop", 32'(k), 32'd2);
    chk32("bp_head_addr_held", InstrAddr, 32'h0);
    step(1'b1, pa_list[2], 1'b0, 1'b1, 1'b1);
    chk1("bp_third_held_at_pop", ar_seen, 1'b0);
    step(1'b1, pa_list[2], 1'b0, 1'b1, 1'b1);
    chk1("bp_third_accepted", ar_seen, 1'b1);
    idle(5);

    // Flush with two reads in flight; 0x40 must return its own data.
    lat_min = 4; lat_max = 4;
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h14, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    lat_min = 1; lat_max = 1;
    accepted = 0;
    for (int i = 0; i < 20 && accepted == 0; i++) begin
      step(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
      if (ar_seen) accepted = 1;
    end
    chk32("flush_0x40_accepted", 32'(accepted), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk32("flush_0x40_instr_addr", InstrAddr, 32'h40);
    idle(3);

    // Misaligned entry queued behind a slow aligned fetch.
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h1C, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h22, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk32("misalign_order_head", InstrAddr, 32'h1C);
    idle(4);

    // Flush together with the only outstanding response.
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'h30, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h34, 1'b0, 1'b1, 1'b1);
    chk1("corner_no_drop_left", ar_seen, 1'b1);
    idle(4);

    // Reset mid-stream with two reads pending; stale responses must be ignored.
    lat_min = 4; lat_max = 4;
    step(1'b1, 32'h50, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h54, 1'b0, 1'b1, 1'b1);
    #2;
    nReset = 1'b0;
    q.delete(); drop = 0;
    #1;
    chk1("rst_mem_req", MemReq, 1'b0);
    chk1("rst_instr_valid", InstrValid, 1'b0);
    chk32("rst_instr", Instr, 32'h0);
    chk32("rst_instr_addr", InstrAddr, 32'h0);
    @(posedge clock); #1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    nReset = 1'b1;
    idle(6);

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      pa = $urandom & 32'h0000_0FFC;
      if ($urandom_range(3, 0) == 0) pa[1:0] = 2'($urandom_range(3, 1));
      rv_hold = ($urandom_range(3, 0) == 0);
      step($urandom_range(3, 0) != 0, pa, $urandom_range(15, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    end
    rv_hold = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
